decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I/RV64I instruction decoder stage sitting between fetch and execute in the npc core. It accepts one instruction word per valid/ready handshake and produces the full control bundle plus a sign-extended immediate one cycle later. A two-entry skid buffer decouples back-pressure, and a flag marks illegal encodings instead of silently defaulting. When XLEN=64 it adds the RV64 word-op and doubleword encodings.

## Interface
- XLEN, 32: datapath width, 32 or 64; any other value is a elaboration error.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage can accept; equals !skid_valid (registered)
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN  pc of bundle
- out_rs1, out_rs2, out_rd  out  5 each  register indices (rd forced 0 when reg_write=0)
- out_imm  out  XLEN  sign-extended immediate (U-type: imm<<12, sign-extended from bit 31)
- out_alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 PASSB=10 NONE=15
- out_src_imm  out  1  ALU operand B = immediate
- out_src_pc  out  1  ALU operand A = pc (AUIPC, JAL)
- out_reg_write  out  1
- out_wb_sel  out  2  0 ALU, 1 memory, 2 pc+4
- out_mem_rd, out_mem_wr  out  1 each
- out_mem_size  out  2  0 B, 1 H, 2 W, 3 D
- out_mem_unsigned  out  1  LBU/LHU/LWU
- out_branch  out  1  conditional branch; funct3 forwarded on out_br_cond
- out_br_cond  out  3
- out_jump  out  1  JAL or JALR
- out_jalr  out  1
- out_word_op  out  1  RV64 *W op, result sign-extended from 32 bits (always 0 when XLEN=32)
- out_illegal  out  1  unsupported encoding; all write/memory/branch controls forced 0

## Operation
- Decoded opcodes: LUI (PASSB), AUIPC, JAL, JALR, BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU), LOAD, STORE, OP-IMM, OP; XLEN=64 adds OP-IMM-32, OP-32, LD, LWU, SD.
- Illegal: unknown opcode; inst[1:0]!=2'b11; OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM shift with nonzero upper funct bits (funct7 for XLEN=32, inst[31:26] excluding bit 30 for XLEN=64; shamt[5]=1 illegal when XLEN=32); load funct3 011/110 when XLEN=32, 111 always; store funct3 >= 011 (XLEN=32) or >= 100 (XLEN=64); branch funct3 010/011; JALR funct3!=0; W-ops other than ADD/SUB/SLL/SRL/SRA (OP-32), ADDI/SLLI/SRLI/SRAI (OP-IMM-32).
- Illegal bundles still handshake out with out_illegal=1, alu_op=NONE.
- Storage: main register M and skid register S, each with valid bit.
- Accept when in_valid && in_ready. If M empty or M drains this cycle (out_ready), decoded word goes to M; else to S.
- When M drains and S valid, S moves to M, S cleared.
- Output: out_valid = M.valid; all out_* driven from M only.
- flush: M.valid, S.valid cleared next edge; an input accepted on the flush cycle is dropped; flush dominates out_ready.

## Timing
- Reset: out_valid=0, in_ready=1, all other outputs 0, alu_op=NONE.
- Latency accept -> out_valid: 1 cycle.
- Throughput: 1 per cycle with out_ready held high.
- out_ready low: first extra instruction lands in S, in_ready falls next cycle; no loss, no duplication, order preserved.
- out_* stable while out_valid && !out_ready.
- rst asserted mid-stream: both entries invalid immediately, outputs to reset values asynchronously.

## Test plan
- After reset, in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000 -> next cycle out_valid=1, alu_op=0, src_imm=1, rd=1, imm=5, reg_write=1.
- Stream add/sub/sra/lui/auipc/jal/jalr/beq/lw/sw back-to-back with out_ready=1 -> one bundle per cycle in order; jal x1,-4: imm=all-ones...FC, wb_sel=2, jump=1; lui 0xFFFFF: imm sign-extended on XLEN=64.
- Hold out_ready=0 while pushing 3 instructions -> 2 accepted, in_ready=0 from cycle 2; release -> both delivered in order, in_ready returns 1.
- Illegal words 0x00000000, 0x0000207B, funct7=0x01 add -> out_illegal=1, reg_write=0, mem_wr=0; XLEN=32 ld (funct3 011) illegal, XLEN=64 legal with mem_size=3.
- XLEN=64: addiw x2,x2,-1 -> word_op=1, imm=0xFFFF_FFFF_FFFF_FFFF; slli shamt=40 legal; XLEN=32 slli shamt=40 illegal.
- flush with M and S full plus in_valid -> next cycle out_valid=0, in_ready=1, flushed and incoming instructions never appear; async rst mid-stall -> out_valid drops before next edge.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decoder with main+skid entries; ports: clk/rst/flush, fetch in_valid/in_ready/in_inst/in_pc, execute out_valid/out_ready plus out_* control bundle
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_op,
  output logic            out_src_imm,
  output logic            out_src_pc,
  output logic            out_reg_write,
  output logic [1:0]      out_wb_sel,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_unsigned,
  output logic            out_branch,
  output logic [2:0]      out_br_cond,
  output logic            out_jump,
  output logic            out_jalr,
  output logic            out_word_op,
  output logic            out_illegal
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end
  localparam bit rv64 = XLEN == 64;
  localparam logic [3:0] a_add = 4'd0, a_sub = 4'd1, a_passb = 4'd10, a_none = 4'd15;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            src_imm;
    logic            src_pc;
    logic            reg_write;
    logic [1:0]      wb_sel;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            branch;
    logic [2:0]      br_cond;
    logic            jump;
    logic            jalr;
    logic            word_op;
    logic            illegal;
  } bundle_t;
  function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
    return f == 3'd0 ? (alt ? a_sub : a_add) : f == 3'd5 ? (alt ? 4'd7 : 4'd6) :
           f == 3'd1 ? 4'd2 : f == 3'd2 ? 4'd3 : f == 3'd3 ? 4'd4 : f == 3'd4 ? 4'd5 :
           f == 3'd6 ? 4'd8 : 4'd9;
  endfunction
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] sh_hi, w_sh;
  logic op_bad, w_f3_bad, bad, m_valid, s_valid, acc;
  logic signed [31:0] imm32;
  bundle_t d, m, s;
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  // shamt[5] is a legal shift-amount bit only on RV64; bit 30 selects arithmetic shift
  assign sh_hi = {in_inst[31], in_inst[29:26], in_inst[25] && !rv64};
  assign w_sh = {in_inst[31], in_inst[29:25]};
  assign op_bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
  assign w_f3_bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
  always_comb begin
    d = '0;
    d.pc = in_pc;
    d.rs1 = in_inst[19:15];
    d.rs2 = in_inst[24:20];
    d.alu_op = a_add;
    imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
    bad = in_inst[1:0] != 2'b11;
    case (in_inst[6:0])
      7'b0110111: begin d.alu_op = a_passb; d.src_imm = 1'b1; d.reg_write = 1'b1; imm32 = {in_inst[31:12], 12'b0}; end
      7'b0010111: begin d.src_pc = 1'b1; d.src_imm = 1'b1; d.reg_write = 1'b1; imm32 = {in_inst[31:12], 12'b0}; end
      7'b1101111: begin
        d.src_pc = 1'b1; d.src_imm = 1'b1; d.reg_write = 1'b1; d.wb_sel = 2'd2; d.jump = 1'b1;
        imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        d.src_imm = 1'b1; d.reg_write = 1'b1; d.wb_sel = 2'd2; d.jump = 1'b1; d.jalr = 1'b1;
        bad = bad | (f3 != 3'd0);
      end
      7'b1100011: begin
        d.alu_op = a_sub; d.branch = 1'b1; d.br_cond = f3;
        imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        bad = bad | (f3[2:1] == 2'b01);
      end
      7'b0000011: begin
        d.src_imm = 1'b1; d.reg_write = 1'b1; d.wb_sel = 2'd1; d.mem_rd = 1'b1;
        d.mem_size = f3[1:0]; d.mem_unsigned = f3[2];
        bad = bad | (f3 == 3'd7) | (!rv64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      7'b0100011: begin
        d.src_imm = 1'b1; d.mem_wr = 1'b1; d.mem_size = f3[1:0];
        imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        bad = bad | (f3 > (rv64 ? 3'd3 : 3'd2));
      end
      7'b0010011: begin
        d.alu_op = alu_of(f3, f3 == 3'd5 && in_inst[30]); d.src_imm = 1'b1; d.reg_write = 1'b1;
        bad = bad | ((f3 == 3'd1 || f3 == 3'd5) && (sh_hi != 6'd0 || (f3 == 3'd1 && in_inst[30])));
      end
      7'b0110011: begin d.alu_op = alu_of(f3, in_inst[30]); d.reg_write = 1'b1; bad = bad | op_bad; end
      7'b0011011: begin
        d.alu_op = alu_of(f3, f3 == 3'd5 && in_inst[30]); d.src_imm = 1'b1; d.reg_write = 1'b1; d.word_op = 1'b1;
        bad = bad | !rv64 | w_f3_bad | (f3 != 3'd0 && (w_sh != 6'd0 || (f3 == 3'd1 && in_inst[30])));
      end
      7'b0111011: begin
        d.alu_op = alu_of(f3, in_inst[30]); d.reg_write = 1'b1; d.word_op = 1'b1;
        bad = bad | !rv64 | op_bad | w_f3_bad;
      end
      default: bad = 1'b1;
    endcase
    d.imm = XLEN'(imm32);
    if (bad) begin
      d.alu_op = a_none;
      d.reg_write = 1'b0;
      d.mem_rd = 1'b0;
      d.mem_wr = 1'b0;
      d.branch = 1'b0;
      d.jump = 1'b0;
      d.jalr = 1'b0;
      d.word_op = 1'b0;
    end
    d.illegal = bad;
    d.rd = d.reg_write ? in_inst[11:7] : 5'd0;
  end
  assign in_ready = !s_valid;
  assign acc = in_valid && !s_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m <= '0;
      m.alu_op <= a_none;
      s <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid || out_ready) begin
      m_valid <= s_valid || acc;
      if (s_valid) begin
        m <= s;
        s_valid <= 1'b0;
      end else if (acc) m <= d;
    end else if (acc) begin
      s <= d;
      s_valid <= 1'b1;
    end
  end
  assign out_valid = m_valid;
  assign out_pc = m.pc;
  assign out_rs1 = m.rs1;
  assign out_rs2 = m.rs2;
  assign out_rd = m.rd;
  assign out_imm = m.imm;
  assign out_alu_op = m.alu_op;
  assign out_src_imm = m.src_imm;
  assign out_src_pc = m.src_pc;
  assign out_reg_write = m.reg_write;
  assign out_wb_sel = m.wb_sel;
  assign out_mem_rd = m.mem_rd;
  assign out_mem_wr = m.mem_wr;
  assign out_mem_size = m.mem_size;
  assign out_mem_unsigned = m.mem_unsigned;
  assign out_branch = m.branch;
  assign out_br_cond = m.br_cond;
  assign out_jump = m.jump;
  assign out_jalr = m.jalr;
  assign out_word_op = m.word_op;
  assign out_illegal = m.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage at XLEN=32 and XLEN=64 side by side
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  int checks = 0, errors = 0;
  logic r32, v32, si32, sp32, rw32, mr32, mw32, mu32, br32, j32, jr32, wo32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0] rs1_32, rs2_32, rd32;
  logic [3:0] alu32;
  logic [1:0] wb32, ms32;
  logic [2:0] bc32;
  logic r64, v64, si64, sp64, rw64, mr64, mw64, mu64, br64, j64, jr64, wo64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0] rs1_64, rs2_64, rd64;
  logic [3:0] alu64;
  logic [1:0] wb64, ms64;
  logic [2:0] bc64;
  always #5 clk = ~clk;
  decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32), .in_inst(in_inst),
    .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready), .out_pc(pc32), .out_rs1(rs1_32),
    .out_rs2(rs2_32), .out_rd(rd32), .out_imm(imm32), .out_alu_op(alu32), .out_src_imm(si32),
    .out_src_pc(sp32), .out_reg_write(rw32), .out_wb_sel(wb32), .out_mem_rd(mr32), .out_mem_wr(mw32),
    .out_mem_size(ms32), .out_mem_unsigned(mu32), .out_branch(br32), .out_br_cond(bc32),
    .out_jump(j32), .out_jalr(jr32), .out_word_op(wo32), .out_illegal(il32)
  );
  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready), .out_pc(pc64), .out_rs1(rs1_64),
    .out_rs2(rs2_64), .out_rd(rd64), .out_imm(imm64), .out_alu_op(alu64), .out_src_imm(si64),
    .out_src_pc(sp64), .out_reg_write(rw64), .out_wb_sel(wb64), .out_mem_rd(mr64), .out_mem_wr(mw64),
    .out_mem_size(ms64), .out_mem_unsigned(mu64), .out_branch(br64), .out_br_cond(bc64),
    .out_jump(j64), .out_jalr(jr64), .out_word_op(wo64), .out_illegal(il64)
  );
  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [8:0]  fl;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // flags = {src_imm, src_pc, wb_sel, mem_rd, mem_wr, branch, jump, jalr}
    tbl = '{
      '{32'h002081B3, 4'd0,  32'h0,        5'd3, 1'b1, 9'b000000000},
      '{32'h40208233, 4'd1,  32'h0,        5'd4, 1'b1, 9'b000000000},
      '{32'h4020D2B3, 4'd7,  32'h0,        5'd5, 1'b1, 9'b000000000},
      '{32'hFFFFF337, 4'd10, 32'hFFFFF000, 5'd6, 1'b1, 9'b100000000},
      '{32'h00001397, 4'd0,  32'h00001000, 5'd7, 1'b1, 9'b110000000},
      '{32'hFFDFF0EF, 4'd0,  32'hFFFFFFFC, 5'd1, 1'b1, 9'b111000010},
      '{32'h00008067, 4'd0,  32'h0,        5'd0, 1'b1, 9'b101000011},
      '{32'h00208463, 4'd1,  32'h8,        5'd0, 1'b0, 9'b000000100},
      '{32'h00412403, 4'd0,  32'h4,        5'd8, 1'b1, 9'b100110000},
      '{32'h00812423, 4'd0,  32'h8,        5'd0, 1'b0, 9'b100001000}
    };
    repeat (2) tick();
    chk("rst_valid32", v32, 0);
    chk("rst_ready32", r32, 1);
    chk("rst_alu32", alu32, 15);
    chk("rst_imm32", imm32, 0);
    chk("rst_rw32", rw32, 0);
    chk("rst_pc32", pc32, 0);
    chk("rst_valid64", v64, 0);
    chk("rst_alu64", alu64, 15);
    rst = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00500093;
    in_pc = 64'h80000000;
    tick();
    chk("addi_valid", v32, 1);
    chk("addi_alu", alu32, 0);
    chk("addi_src_imm", si32, 1);
    chk("addi_rd", rd32, 1);
    chk("addi_imm", imm32, 5);
    chk("addi_rw", rw32, 1);
    chk("addi_pc", pc32, 32'h80000000);
    chk("addi_imm64", imm64, 5);
    for (int k = 0; k < 10; k++) begin
      in_inst = tbl[k].inst;
      in_pc = 64'h1000 + 64'(k * 4);
      tick();
      chk($sformatf("s%0d_valid", k), v32, 1);
      chk($sformatf("s%0d_pc", k), pc32, 32'h1000 + 32'(k * 4));
      chk($sformatf("s%0d_alu", k), alu32, tbl[k].alu);
      chk($sformatf("s%0d_rd", k), rd32, tbl[k].rd);
      chk($sformatf("s%0d_rw", k), rw32, tbl[k].rw);
      chk($sformatf("s%0d_flags", k), {si32, sp32, wb32, mr32, mw32, br32, j32, jr32}, tbl[k].fl);
      chk($sformatf("s%0d_illegal", k), il32, 0);
      chk($sformatf("s%0d_alu64", k), alu64, tbl[k].alu);
      if (tbl[k].fl[8] || tbl[k].fl[2]) begin
        chk($sformatf("s%0d_imm", k), imm32, tbl[k].imm);
        chk($sformatf("s%0d_imm64", k), imm64, {{32{tbl[k].imm[31]}}, tbl[k].imm});
      end
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", v32, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00500093;
    in_pc = 64'h2000;
    tick();
    chk("stall1_valid", v32, 1);
    chk("stall1_ready", r32, 1);
    in_pc = 64'h2004;
    tick();
    chk("stall2_ready", r32, 0);
    chk("stall2_ready64", r64, 0);
    chk("stall2_pc", pc32, 32'h2000);
    in_pc = 64'h2008;
    tick();
    chk("stall3_ready", r32, 0);
    chk("stall3_pc", pc32, 32'h2000);
    chk("stall3_imm", imm32, 5);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rel1_valid", v32, 1);
    chk("rel1_pc", pc32, 32'h2004);
    chk("rel1_ready", r32, 1);
    tick();
    chk("rel2_valid", v32, 0);
    in_valid = 1'b1;
    foreach (tbl[k]) begin
      if (k < 3) begin
        in_inst = k == 0 ? 32'h00000000 : k == 1 ? 32'h0000207B : 32'h022081B3;
        tick();
        chk($sformatf("ill%0d_illegal", k), il32, 1);
        chk($sformatf("ill%0d_rw", k), rw32, 0);
        chk($sformatf("ill%0d_mem_wr", k), mw32, 0);
        chk($sformatf("ill%0d_alu", k), alu32, 15);
        chk($sformatf("ill%0d_rd", k), rd32, 0);
        chk($sformatf("ill%0d_illegal64", k), il64, 1);
      end
    end
    in_inst = 32'h00813403;
    tick();
    chk("ld_illegal32", il32, 1);
    chk("ld_mem_rd32", mr32, 0);
    chk("ld_illegal64", il64, 0);
    chk("ld_size64", ms64, 3);
    chk("ld_mem_rd64", mr64, 1);
    chk("ld_rd64", rd64, 8);
    in_inst = 32'h00813423;
    tick();
    chk("sd_illegal32", il32, 1);
    chk("sd_mem_wr32", mw32, 0);
    chk("sd_illegal64", il64, 0);
    chk("sd_mem_wr64", mw64, 1);
    chk("sd_size64", ms64, 3);
    in_inst = 32'hFFF1011B;
    tick();
    chk("addiw_illegal32", il32, 1);
    chk("addiw_word32", wo32, 0);
    chk("addiw_illegal64", il64, 0);
    chk("addiw_word64", wo64, 1);
    chk("addiw_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_rd64", rd64, 2);
    in_inst = 32'h02809093;
    tick();
    chk("slli40_illegal32", il32, 1);
    chk("slli40_illegal64", il64, 0);
    chk("slli40_alu64", alu64, 2);
    in_inst = 32'h4030D093;
    tick();
    chk("srai_illegal32", il32, 0);
    chk("srai_alu32", alu32, 7);
    chk("srai_imm32", imm32, 32'h403);
    chk("srai_alu64", alu64, 7);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_inst = 32'h00500093;
    in_pc = 64'h3000;
    tick();
    in_pc = 64'h3004;
    tick();
    chk("pre_flush_ready", r32, 0);
    in_pc = 64'h3008;
    flush = 1'b1;
    tick();
    chk("flush_valid", v32, 0);
    chk("flush_ready", r32, 1);
    chk("flush_valid64", v64, 0);
    out_ready = 1'b1;
    in_pc = 64'h3010;
    tick();
    chk("flush_drop_valid", v32, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_flush_valid", v32, 0);
    in_valid = 1'b1;
    in_pc = 64'h3020;
    tick();
    chk("resume_valid", v32, 1);
    chk("resume_pc", pc32, 32'h3020);
    out_ready = 1'b0;
    in_pc = 64'h3024;
    tick();
    chk("prerst_ready", r32, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", v32, 0);
    chk("arst_ready", r32, 1);
    chk("arst_alu", alu32, 15);
    chk("arst_pc", pc32, 0);
    chk("arst_valid64", v64, 0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_valid", v32, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
